// File: rtl/rst_sequencer.sv
// -----------------------------------------------------------------------------
// rst_sequencer
//
// Staged reset generator. Holds the core reset for STRETCH_CYCLES clocks after
// the reset source goes away, releases the display reset STAGE_GAP clocks
// later, and re-enters the sequence on a soft-reset request or on watchdog
// expiry. Every output is a flop, so downstream blocks see clean synchronous
// resets.
//
// Parameters
//   STRETCH_CYCLES  minimum core reset width in clocks (>= 1)
//   STAGE_GAP       clocks between core and display release (>= 1)
//   WDT_CYCLES      watchdog timeout in clocks (>= 2)
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high platform power-on reset
//   soft_req   in   soft-reset request, level or pulse
//   wdt_en     in   watchdog enable
//   wdt_kick   in   watchdog service pulse
//   rst_core   out  active-high reset for core logic
//   rst_disp   out  active-high reset for display logic
//   ready      out  high when both resets are released
//   cause      out  last reset cause: 0 POR, 1 soft, 2 watchdog
//   wdt_fired  out  one-clock pulse on watchdog expiry
// -----------------------------------------------------------------------------
module rst_sequencer #(
  parameter int STRETCH_CYCLES = 16,
  parameter int STAGE_GAP      = 4,
  parameter int WDT_CYCLES     = 2**20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       soft_req,
  input  logic       wdt_en,
  input  logic       wdt_kick,
  output logic       rst_core,
  output logic       rst_disp,
  output logic       ready,
  output logic [1:0] cause,
  output logic       wdt_fired
);

  localparam int MAX_STAGE = (STRETCH_CYCLES > STAGE_GAP) ? STRETCH_CYCLES : STAGE_GAP;
  localparam int CNT_W     = $clog2(MAX_STAGE + 1);
  localparam int WDT_W     = $clog2(WDT_CYCLES + 1);

  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
  localparam logic [WDT_W-1:0] WDT_LAST     = WDT_W'(WDT_CYCLES - 1);

  localparam logic [1:0] CAUSE_POR  = 2'd0;
  localparam logic [1:0] CAUSE_SOFT = 2'd1;
  localparam logic [1:0] CAUSE_WDT  = 2'd2;

  typedef enum logic [1:0] {
    S_HOLD    = 2'd0,
    S_CORE_UP = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_stage_cnt;
  logic [WDT_W-1:0] r_wdt_cnt;
  logic             r_rst_core;
  logic             r_rst_disp;
  logic             r_ready;
  logic [1:0]       r_cause;
  logic             r_wdt_fired;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_HOLD;
      r_stage_cnt <= '0;
      r_wdt_cnt   <= '0;
      r_rst_core  <= 1'b1;
      r_rst_disp  <= 1'b1;
      r_ready     <= 1'b0;
      r_cause     <= CAUSE_POR;
      r_wdt_fired <= 1'b0;
    end else if (soft_req) begin
      // A held request parks the stretch counter at 0, so release timing
      // starts from the first clock the request is low.
      r_state     <= S_HOLD;
      r_stage_cnt <= '0;
      r_wdt_cnt   <= '0;
      r_rst_core  <= 1'b1;
      r_rst_disp  <= 1'b1;
      r_ready     <= 1'b0;
      r_cause     <= CAUSE_SOFT;
      r_wdt_fired <= 1'b0;
    end else begin
      r_wdt_fired <= 1'b0;
      case (r_state)
        S_HOLD: begin
          r_wdt_cnt <= '0;
          if (r_stage_cnt == STRETCH_LAST) begin
            r_state     <= S_CORE_UP;
            r_stage_cnt <= '0;
            r_rst_core  <= 1'b0;
          end else begin
            r_stage_cnt <= r_stage_cnt + CNT_W'(1);
          end
        end
        S_CORE_UP: begin
          r_wdt_cnt <= '0;
          if (r_stage_cnt == GAP_LAST) begin
            r_state     <= S_RUN;
            r_stage_cnt <= '0;
            r_rst_disp  <= 1'b0;
            r_ready     <= 1'b1;
          end else begin
            r_stage_cnt <= r_stage_cnt + CNT_W'(1);
          end
        end
        S_RUN: begin
          // A kick on the terminal count wins over expiry.
          if (!wdt_en || wdt_kick) begin
            r_wdt_cnt <= '0;
          end else if (r_wdt_cnt == WDT_LAST) begin
            r_state     <= S_HOLD;
            r_stage_cnt <= '0;
            r_wdt_cnt   <= '0;
            r_rst_core  <= 1'b1;
            r_rst_disp  <= 1'b1;
            r_ready     <= 1'b0;
            r_cause     <= CAUSE_WDT;
            r_wdt_fired <= 1'b1;
          end else begin
            r_wdt_cnt <= r_wdt_cnt + WDT_W'(1);
          end
        end
        default: begin
          r_state     <= S_HOLD;
          r_stage_cnt <= '0;
          r_wdt_cnt   <= '0;
          r_rst_core  <= 1'b1;
          r_rst_disp  <= 1'b1;
          r_ready     <= 1'b0;
        end
      endcase
    end
  end

  assign rst_core  = r_rst_core;
  assign rst_disp  = r_rst_disp;
  assign ready     = r_ready;
  assign cause     = r_cause;
  assign wdt_fired = r_wdt_fired;

endmodule
